button_pulser_array: RTL and testbench

Parametrised N-channel button front end. Each channel synchronises a raw pad input, debounces it, and emits single-cycle pulses. A pulse fires on each accepted press. In auto-repeat mode, further pulses fire at a programmable rate while the button is held. The block sits between board push-buttons and the UART/control logic, which consume one pulse per command.

---
 rtl/button_pulser_pkg.sv | 16 +
 rtl/button_pulser_ch.sv | 110 +++++++++++
 rtl/button_pulser_array.sv | 38 +++
 tb/tb_button_pulser_array.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/button_pulser_pkg.sv
// Shared state encoding and sizing helper for the button pulser channels.
package button_pulser_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'b00,
      ST_FIRE     = 2'b01,
      ST_HOLD     = 2'b11,
      ST_WAIT_REL = 2'b10
   } state_t;

   // Bits needed for a counter that must reach max_val (at least one bit).
   function automatic int cnt_w(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/button_pulser_ch.sv
// One button channel: two-flop synchroniser, debouncer and press/repeat FSM.
module button_pulser_ch
   import button_pulser_pkg::*;
#(
   parameter bit ACTIVE_LOW      = 1'b1,
   parameter int DEBOUNCE_CYCLES = 1000,
   parameter bit REPEAT_EN       = 1'b0,
   parameter int REPEAT_DELAY    = 50_000_000,
   parameter int REPEAT_PERIOD   = 10_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   input  logic ch_en,
   output logic pulse,
   output logic held
);

   localparam logic INACTIVE = ACTIVE_LOW ? 1'b1 : 1'b0;
   localparam int   DB_W     = cnt_w(DEBOUNCE_CYCLES - 1);
   localparam int   HOLD_MAX = ((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD) - 2;
   localparam int   HC_W     = cnt_w(HOLD_MAX);

   localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HC_W-1:0] DELAY_LAST  = HC_W'(REPEAT_DELAY - 2);
   localparam logic [HC_W-1:0] PERIOD_LAST = HC_W'(REPEAT_PERIOD - 2);

   logic            s1, s2;
   logic            db;
   logic [DB_W-1:0] cnt;
   logic            p;
   state_t          st;
   logic            rep;
   logic [HC_W-1:0] hcnt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         s1 <= INACTIVE;
         s2 <= INACTIVE;
      end else begin
         s1 <= btn;
         s2 <= s1;
      end
   end

   // Any sample matching the stable level restarts the run, so short glitches vanish.
   always_ff @(posedge clk) begin
      if (!rst) begin
         db  <= INACTIVE;
         cnt <= '0;
      end else if (s2 == db) begin
         cnt <= '0;
      end else if (cnt == DB_LAST) begin
         db  <= s2;
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign p = ACTIVE_LOW ? ~db : db;

   always_ff @(posedge clk) begin
      if (!rst) begin
         st   <= ST_IDLE;
         rep  <= 1'b0;
         hcnt <= '0;
      end else begin
         case (st)
            ST_IDLE: begin
               if (!ch_en)  st <= ST_WAIT_REL;
               else if (p)  st <= ST_FIRE;
            end
            ST_FIRE: begin
               if (!ch_en) begin
                  st <= ST_WAIT_REL;
               end else if (p) begin
                  st   <= ST_HOLD;
                  hcnt <= '0;
               end else begin
                  st  <= ST_IDLE;
                  rep <= 1'b0;
               end
            end
            ST_HOLD: begin
               // hcnt only advances with repeat enabled, so it can never wrap on a long hold.
               if (!ch_en) begin
                  st <= ST_WAIT_REL;
               end else if (!p) begin
                  st  <= ST_IDLE;
                  rep <= 1'b0;
               end else if (REPEAT_EN && (hcnt == (rep ? PERIOD_LAST : DELAY_LAST))) begin
                  st  <= ST_FIRE;
                  rep <= 1'b1;
               end else if (REPEAT_EN) begin
                  hcnt <= hcnt + 1'b1;
               end
            end
            ST_WAIT_REL: begin
               if (ch_en && !p) st <= ST_IDLE;
            end
            default: st <= ST_IDLE;
         endcase
      end
   end

   assign pulse = (st == ST_FIRE);
   assign held  = p;

endmodule

// File: rtl/button_pulser_array.sv
// N independent button channels; pulse_any flags a pulse on any of them.
module button_pulser_array #(
   parameter int N_CH            = 4,
   parameter bit ACTIVE_LOW      = 1'b1,
   parameter int DEBOUNCE_CYCLES = 1000,
   parameter bit REPEAT_EN       = 1'b0,
   parameter int REPEAT_DELAY    = 50_000_000,
   parameter int REPEAT_PERIOD   = 10_000_000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_CH-1:0] btn,
   input  logic [N_CH-1:0] ch_en,
   output logic [N_CH-1:0] pulse,
   output logic [N_CH-1:0] held,
   output logic            pulse_any
);

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      button_pulser_ch #(
         .ACTIVE_LOW      (ACTIVE_LOW),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_EN       (REPEAT_EN),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD)
      ) u_ch (
         .clk   (clk),
         .rst   (rst),
         .btn   (btn[g]),
         .ch_en (ch_en[g]),
         .pulse (pulse[g]),
         .held  (held[g])
      );
   end

   assign pulse_any = |pulse;

endmodule

// File: tb/tb_button_pulser_array.sv
// Two configurations (active-low one-shot, active-high auto-repeat) against a cycle model.
module tb_button_pulser_array;
   localparam int N   = 4;
   localparam int D   = 4;
   localparam int DLY = 20;
   localparam int PER = 8;
   localparam int READY = 0, FIRED = 1, HOLDING = 2, BLOCKED = 3;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [N-1:0] btn_a, en_a, btn_r, en_r;
   logic [N-1:0] pulse_a, held_a, pulse_r, held_r;
   logic         any_a, any_r;

   int checks = 0, errors = 0, cyc = 0;

   // Model state, [0] = dut_a, [1] = dut_r
   bit m_s1 [2][N], m_s2 [2][N], m_db [2][N], m_pulse [2][N];
   bit m_win[2][N][D];
   int m_st [2][N], m_last [2][N], m_gap [2][N];

   always #5 clk = ~clk;

   button_pulser_array #(.N_CH(N), .ACTIVE_LOW(1'b1), .DEBOUNCE_CYCLES(D), .REPEAT_EN(1'b0),
                         .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER)) dut_a (
      .clk(clk), .rst(rst), .btn(btn_a), .ch_en(en_a),
      .pulse(pulse_a), .held(held_a), .pulse_any(any_a));

   button_pulser_array #(.N_CH(N), .ACTIVE_LOW(1'b0), .DEBOUNCE_CYCLES(D), .REPEAT_EN(1'b1),
                         .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER)) dut_r (
      .clk(clk), .rst(rst), .btn(btn_r), .ch_en(en_r),
      .pulse(pulse_r), .held(held_r), .pulse_any(any_r));

   task automatic chk(input string tag, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         if (errors <= 40) $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // Behaviour at one rising edge: pad seen 2 edges late, level accepted after D
   // consecutive differing samples, pulses scheduled by elapsed time since the last one.
   task automatic model_edge(input int d, input bit al, input bit rep_en,
                             input logic [N-1:0] b, input logic [N-1:0] e);
      for (int c = 0; c < N; c++) begin
         bit p_old, flip;
         if (!rst) begin
            m_s1[d][c] = 0; m_s2[d][c] = 0; m_db[d][c] = 0; m_pulse[d][c] = 0;
            m_st[d][c] = READY; m_gap[d][c] = DLY; m_last[d][c] = 0;
            for (int i = 0; i < D; i++) m_win[d][c][i] = 0;
            continue;
         end
         p_old = m_db[d][c];
         m_pulse[d][c] = 0;
         case (m_st[d][c])
            READY:
               if (e[c] !== 1'b1) m_st[d][c] = BLOCKED;
               else if (p_old) begin
                  m_pulse[d][c] = 1; m_st[d][c] = FIRED; m_last[d][c] = cyc;
               end
            FIRED:
               if (e[c] !== 1'b1) m_st[d][c] = BLOCKED;
               else if (p_old) m_st[d][c] = HOLDING;
               else begin m_st[d][c] = READY; m_gap[d][c] = DLY; end
            HOLDING:
               if (e[c] !== 1'b1) m_st[d][c] = BLOCKED;
               else if (!p_old) begin m_st[d][c] = READY; m_gap[d][c] = DLY; end
               else if (rep_en && (cyc - m_last[d][c] == m_gap[d][c])) begin
                  m_pulse[d][c] = 1; m_st[d][c] = FIRED; m_last[d][c] = cyc; m_gap[d][c] = PER;
               end
            default:
               if (e[c] === 1'b1 && !p_old) m_st[d][c] = READY;
         endcase
         for (int i = 0; i < D - 1; i++) m_win[d][c][i] = m_win[d][c][i+1];
         m_win[d][c][D-1] = m_s2[d][c];
         flip = 1;
         for (int i = 0; i < D; i++) if (m_win[d][c][i] == m_db[d][c]) flip = 0;
         if (flip) m_db[d][c] = !m_db[d][c];
         m_s2[d][c] = m_s1[d][c];
         m_s1[d][c] = al ? !b[c] : b[c];
      end
   endtask

   task automatic step();
      logic [N-1:0] ep_a, eh_a, ep_r, eh_r;
      @(posedge clk);
      cyc++;
      model_edge(0, 1'b1, 1'b0, btn_a, en_a);
      model_edge(1, 1'b0, 1'b1, btn_r, en_r);
      #1;
      for (int c = 0; c < N; c++) begin
         ep_a[c] = m_pulse[0][c]; eh_a[c] = m_db[0][c];
         ep_r[c] = m_pulse[1][c]; eh_r[c] = m_db[1][c];
      end
      chk("pulse_a", int'(pulse_a), int'(ep_a));
      chk("held_a",  int'(held_a),  int'(eh_a));
      chk("any_a",   int'(any_a),   int'(|ep_a));
      chk("pulse_r", int'(pulse_r), int'(ep_r));
      chk("held_r",  int'(held_r),  int'(eh_r));
      chk("any_r",   int'(any_r),   int'(|ep_r));
   endtask

   initial begin
      int first, n, other, held_e, extra;
      int offs[$];
      int exp_offs[6] = '{20, 28, 36, 44, 52, 60};

      btn_a = '1; en_a = '1; btn_r = '0; en_r = '1;
      repeat (3) step();
      chk("reset_pulse", int'(pulse_a | pulse_r), 0);
      chk("reset_held",  int'(held_a | held_r), 0);
      chk("reset_any",   int'(any_a | any_r), 0);
      rst = 1'b1;
      repeat (5) step();

      // Clean press on ch0
      btn_a[0] = 1'b0; first = -1; held_e = -1; n = 0; other = 0;
      for (int k = 1; k <= 100; k++) begin
         step();
         if (pulse_a[0]) begin n++; if (first < 0) first = k; end
         if (held_a[0] && held_e < 0) held_e = k;
         if (pulse_a[3:1] != 0) other++;
      end
      chk("clean_edge", first, 7);
      chk("clean_count", n, 1);
      chk("clean_held_edge", held_e, 6);
      chk("clean_other", other, 0);
      btn_a[0] = 1'b1;
      repeat (15) step();

      // Bounce on ch1, then stable press
      n = 0;
      for (int i = 0; i < 10; i++) begin
         btn_a[1] = (i % 2 == 0) ? 1'b0 : 1'b1;
         repeat (2) begin step(); if (pulse_a[1]) n++; end
      end
      chk("bounce_quiet", n, 0);
      btn_a[1] = 1'b0; first = -1; n = 0;
      for (int k = 1; k <= 30; k++) begin
         step();
         if (pulse_a[1]) begin n++; if (first < 0) first = k; end
      end
      chk("bounce_edge", first, 7);
      chk("bounce_count", n, 1);
      btn_a[1] = 1'b1;
      repeat (15) step();

      // Auto-repeat on dut_r ch0
      btn_r[0] = 1'b1; first = -1;
      for (int k = 1; k <= 20 && first < 0; k++) begin
         step();
         if (pulse_r[0]) first = k;
      end
      chk("repeat_first_edge", first, 7);
      offs.delete();
      for (int k = 1; k <= 60; k++) begin
         step();
         if (pulse_r[0]) offs.push_back(k);
      end
      btn_r[0] = 1'b0; extra = 0;
      repeat (30) begin step(); if (pulse_r[0]) extra++; end
      chk("repeat_count", offs.size(), 6);
      for (int i = 0; i < 6; i++) chk("repeat_offset", (i < offs.size()) ? offs[i] : -1, exp_offs[i]);
      chk("repeat_after_release", extra, 0);

      // Enable gating on ch2
      btn_a[2] = 1'b0; n = 0;
      repeat (10) begin step(); if (pulse_a[2]) n++; end
      chk("gate_first", n, 1);
      en_a[2] = 1'b0; n = 0;
      repeat (5) begin step(); if (pulse_a[2]) n++; end
      en_a[2] = 1'b1;
      repeat (20) begin step(); if (pulse_a[2]) n++; end
      chk("gate_quiet", n, 0);
      btn_a[2] = 1'b1;
      repeat (15) step();
      btn_a[2] = 1'b0; n = 0;
      repeat (15) begin step(); if (pulse_a[2]) n++; end
      chk("gate_repress", n, 1);
      btn_a[2] = 1'b1;
      repeat (15) step();

      // Reset mid-hold on ch3
      btn_a[3] = 1'b0;
      repeat (20) step();
      rst = 1'b0;
      step();
      chk("rst_mid_pulse", int'(pulse_a), 0);
      chk("rst_mid_held",  int'(held_a), 0);
      chk("rst_mid_any",   int'(any_a), 0);
      rst = 1'b1; first = -1; n = 0;
      for (int k = 1; k <= 20; k++) begin
         step();
         if (pulse_a[3]) begin n++; if (first < 0) first = k; end
      end
      chk("rst_refire_edge", first, 7);
      chk("rst_refire_count", n, 1);
      btn_a[3] = 1'b1;
      repeat (15) step();

      // Simultaneous press on all dut_r channels
      btn_r = '1; first = -1; n = 0; other = 0;
      for (int k = 1; k <= 20; k++) begin
         step();
         if (pulse_r == 4'hF && first < 0) first = k;
         if (any_r) n++;
         if (pulse_r != 0 && pulse_r != 4'hF) other++;
      end
      chk("simul_edge", first, 7);
      chk("simul_any_count", n, 1);
      chk("simul_partial", other, 0);
      btn_r = '0;
      repeat (15) step();

      // Random pads, enables and occasional reset
      for (int k = 0; k < 4000; k++) begin
         for (int c = 0; c < N; c++) begin
            if ($urandom_range(11) == 0) btn_a[c] = ~btn_a[c];
            if ($urandom_range(24) == 0) btn_r[c] = ~btn_r[c];
            if ($urandom_range(199) == 0) en_a[c] = ~en_a[c];
            if ($urandom_range(199) == 0) en_r[c] = ~en_r[c];
         end
         rst = ($urandom_range(999) != 0);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
